alu_add32_seq: RTL
==================

# alu_add32_seq

Two-pass 32-bit add/subtract sequencer that sits directly upstream of the 16-bit ripple-carry flag adder. It drives that adder's A/B/Cin inputs and consumes its Sum/Co/flag outputs over two cycles, low half first and then high half. The low-half carry is chained into the high pass, and the per-half flags are merged into 32-bit flags. Operands arrive and results leave on valid/ready handshakes.

## Interface
- No parameters. Width is fixed at 32-bit operands over a 16-bit adder.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request.
- `in_op` in 2: 00 ADD, 01 ADC, 10 SUB, 11 SBB.
- `in_a`, `in_b` in 32: operands.
- `in_cin` in 1: carry-in for ADC/SBB. For SBB, 1 means no borrow.
- `add_a`, `add_b` out 16: drive the adder's A and B.
- `add_cin` out 1: drives the adder's Cin.
- `add_sum` in 16, `add_co` in 1: the adder's Sum and Co.
- `add_zero`, `add_parity`, `add_overflow` in 1: the adder's Zero, Parity (1 = even ones), and Overflow.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out 32: result.
- `out_n`, `out_z`, `out_c`, `out_v`, `out_p` out 1: sign, zero, carry, overflow, and even-parity flags.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- IDLE: on `in_valid` & `in_ready`:
  - latch `a_r` = `in_a`.
  - latch `b_r` = `in_b` for ADD/ADC, or ~`in_b` for SUB/SBB.
  - latch `c0_r`: ADD 0, ADC `in_cin`, SUB 1, SBB `in_cin`.
  - go to LO.
- LO:
  - drive `add_a` = `a_r[15:0]`, `add_b` = `b_r[15:0]`, `add_cin` = `c0_r`.
  - at the clock edge, register `lo_sum` = `add_sum`, `lo_co` = `add_co`, `lo_z` = `add_zero`, `lo_p` = `add_parity`.
  - go to HI.
- HI:
  - drive `add_a` = `a_r[31:16]`, `add_b` = `b_r[31:16]`, `add_cin` = `lo_co`.
  - at the clock edge, register `out_result` = {`add_sum`, `lo_sum`}.
  - register `out_n` = `add_sum[15]`, `out_z` = `lo_z` & `add_zero`, `out_c` = `add_co`, `out_v` = `add_overflow`.
  - register `out_p` = ~(`lo_p` ^ `add_parity`).
  - go to DONE.
- DONE:
  - result and flags are held stable.
  - on `out_ready`, go to IDLE. Otherwise stay.
- Adder drive in IDLE and DONE: `add_a` = `add_b` = 0, `add_cin` = 0. Drive is combinational from state and registers.
- Subtraction convention: `out_c` = 1 means no borrow. `out_v` is two's-complement overflow of A + ~B + cin.
- `in_valid` and input data are ignored outside IDLE. Operands are captured only at acceptance.

## Timing
- Reset (async assert, any state):
  - state IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `out_result` = 0, all flags 0.
  - internal registers 0.
  - `add_*` outputs 0.
- Accept at edge k:
  - LO during cycle k..k+1.
  - HI during k+1..k+2.
  - `out_valid` = 1 after edge k+2 (latency 2 cycles).
- With `out_ready` held high, DONE → IDLE at edge k+3. The next accept is no earlier than edge k+4 (one op per 4 cycles).
- Reset mid-operation (LO/HI/DONE): the operation is dropped, no `out_valid` pulse, IDLE on release.
- The adder path is combinational. The adder's A/B/Cin → Sum/flags must settle within one clock.

## Test plan
- ADD 0x0000FFFF + 0x00000001 → result 0x00010000, C=0, Z=0, N=0, V=0, P=0. Carry crosses halves via `add_cin`=1 in HI.
- SUB 0x12345678 − 0x12345678 → result 0x00000000, Z=1, C=1, V=0, N=0, P=1.
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, N=1, V=1, C=0, P=0.
- ADC 0xFFFFFFFF + 0x00000000, `in_cin`=1 → result 0x00000000, C=1, Z=1, V=0. SBB 0x00000000 − 0x00000001, `in_cin`=1 → 0xFFFFFFFF, C=0, N=1, P=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`.
  - result and flags stay stable.
  - `in_ready`=0.
  - a toggling `in_valid` with new data is ignored.
  - release `out_ready` → one transfer, then IDLE.
- Assert `rst_n`=0 while in HI → all outputs return to reset values immediately. After release, `in_ready`=1 and no stale `out_valid`.

Source files
------------

// File: rtl/alu_add32_seq.sv
// Two-pass 32-bit add/subtract sequencer driving an external 16-bit flag adder.
// Low half is added first; its carry feeds the high pass and the flags are merged.
module alu_add32_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_cin,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_co,
    input  logic        add_zero,
    input  logic        add_parity,
    input  logic        add_overflow,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_n,
    output logic        out_z,
    output logic        out_c,
    output logic        out_v,
    output logic        out_p,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    state_t      state, state_nxt;
    logic [31:0] a_r, b_r;
    logic        c0_r;
    logic [15:0] lo_sum;
    logic        lo_co, lo_z, lo_p;
    logic        accept;

    // Valid/ready: a transfer happens on a rising edge where both valid and
    // ready are high; valid never waits on ready, and data is held while valid.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        add_a     = 16'd0;
        add_b     = 16'd0;
        add_cin   = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = LO;
            LO: begin
                add_a     = a_r[15:0];
                add_b     = b_r[15:0];
                add_cin   = c0_r;
                state_nxt = HI;
            end
            HI: begin
                add_a     = a_r[31:16];
                add_b     = b_r[31:16];
                add_cin   = lo_co;
                state_nxt = DONE;
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_r        <= 32'd0;
            b_r        <= 32'd0;
            c0_r       <= 1'b0;
            lo_sum     <= 16'd0;
            lo_co      <= 1'b0;
            lo_z       <= 1'b0;
            lo_p       <= 1'b0;
            out_result <= 32'd0;
            out_n      <= 1'b0;
            out_z      <= 1'b0;
            out_c      <= 1'b0;
            out_v      <= 1'b0;
            out_p      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept) begin
                a_r <= in_a;
                // Subtraction is A + ~B + cin; SUB forces cin=1 (no borrow).
                b_r <= in_op[1] ? ~in_b : in_b;
                case (in_op)
                    OP_ADD:  c0_r <= 1'b0;
                    OP_ADC:  c0_r <= in_cin;
                    OP_SUB:  c0_r <= 1'b1;
                    default: c0_r <= in_cin;
                endcase
            end
            if (state == LO) begin
                lo_sum <= add_sum;
                lo_co  <= add_co;
                lo_z   <= add_zero;
                lo_p   <= add_parity;
            end
            if (state == HI) begin
                out_result <= {add_sum, lo_sum};
                out_n      <= add_sum[15];
                out_z      <= lo_z & add_zero;
                out_c      <= add_co;
                out_v      <= add_overflow;
                // Two even halves or two odd halves make an even whole.
                out_p      <= ~(lo_p ^ add_parity);
            end
        end
    end

endmodule
